ts_frame_tx: RTL and testbench

Downstream consumer of the 7-in-1 TS multiplexer. It handshakes on the multiplexer's ready/ack pair and collects the 8-byte head and the 1316-byte body. It then emits one contiguous output frame: a 4-byte sequence header, the 6 TS bytes carried in the head, and the body. It also checks the embedded length field.

---
 rtl/ts_frame_pkg.sv | 30 +++
 rtl/ts_frame_cksum.sv | 35 +++
 rtl/ts_frame_tx.sv | 241 ++++++++++++++++++++++++
 tb/tb_ts_frame_tx.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ts_frame_pkg.sv
// ts_frame_pkg: FSM encoding and framing constants for ts_frame_tx.
// TS_FRAME_CHK_EN selects the header flags value (checksum framing).
package ts_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ_HEAD = 3'd1,
        ST_GET_HEAD = 3'd2,
        ST_SEND_HDR = 3'd3,
        ST_BODY     = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    localparam logic [7:0]  TS_SYNC_BYTE = 8'h5A;
    localparam int          HEAD_LEN     = 8;
    localparam int          TS_PKT_LEN   = 188;
    localparam logic [15:0] NOMINAL_LEN  = 16'h052C;

`ifdef TS_FRAME_CHK_EN
    localparam logic [7:0]  HDR_FLAGS    = 8'h01;
`else
    localparam logic [7:0]  HDR_FLAGS    = 8'h00;
`endif

    // Length value the head should carry for a given body byte count.
    function automatic logic [15:0] frame_len(input logic [15:0] body_cnt);
        return 16'(HEAD_LEN) + body_cnt;
    endfunction

endpackage

// File: rtl/ts_frame_cksum.sv
// ts_frame_cksum: byte-wise XOR accumulator with clear and enable.
// Used by ts_frame_tx only when TS_FRAME_CHK_EN is defined.
module ts_frame_cksum (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] byte_i,
    output logic [7:0] acc_o
);

    logic [7:0] acc_q, acc_d;

    // Clear wins over accumulate.
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = 8'h00;
        end else if (en_i) begin
            acc_d = acc_q ^ byte_i;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            acc_q <= 8'h00;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/ts_frame_tx.sv
// ts_frame_tx: collects head/body from the TS mux and emits one framed burst.
// Optional TS_FRAME_CHK_EN appends an XOR checksum byte after the body.
module ts_frame_tx
    import ts_frame_pkg::*;
#(
    parameter int BODY_LEN = 7 * TS_PKT_LEN,
    parameter int TIMEOUT  = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ready,
    output logic        o_ack,
    input  logic [7:0]  iv_ts,
    input  logic        i_ts_en,
    output logic [7:0]  ov_data,
    output logic        o_data_en,
    output logic        o_sof,
    output logic        o_eof,
    output logic        o_len_err,
    output logic [15:0] ov_frame_cnt
);

    state_e      state_q, state_d;
    logic [7:0]  head_q [HEAD_LEN];
    logic [7:0]  head_d [HEAD_LEN];
    logic [2:0]  hcnt_q, hcnt_d;
    logic [3:0]  hidx_q, hidx_d;
    logic [15:0] bcnt_q, bcnt_d;
    logic [15:0] idle_q, idle_d;
    logic [15:0] seq_q, seq_d;
    logic [15:0] fcnt_q, fcnt_d;
    logic [7:0]  data_q, data_d;
    logic        full_q, full_d;
    logic        den_q, den_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic        ack_q, ack_d;
    logic        lerr_q, lerr_d;
    logic [7:0]  hdr_byte;
    logic [7:0]  ck_acc;
    logic        ck_clr, ck_en;
    logic        hdr_go, idle_run, tmo;
    logic        last_now, fin, cks_go;

    assign hdr_go   = (state_q == ST_GET_HEAD) && i_ts_en
                    && (hcnt_q == 3'd7);
    assign idle_run = !i_ts_en
                    && ((state_q == ST_GET_HEAD)
                    || ((state_q == ST_BODY) && (bcnt_q == '0)));
    assign tmo      = idle_run && (idle_q == 16'(TIMEOUT - 1));
    // The byte now on ov_data is the final body byte.
    assign last_now = (state_q == ST_BODY)
                    && (full_q || ((bcnt_q != '0) && !i_ts_en));

`ifdef TS_FRAME_CHK_EN
    ts_frame_cksum u_cksum (
        .clk_i   (i_clk),
        .reset_i (i_reset),
        .clr_i   (ck_clr),
        .en_i    (ck_en),
        .byte_i  (data_d),
        .acc_o   (ck_acc)
    );
    assign fin    = (state_q == ST_BODY) && eof_q;
    assign cks_go = last_now && !fin;
    assign o_eof  = eof_q;
`else
    logic unused_ck;
    assign unused_ck = ck_clr ^ ck_en;
    assign ck_acc    = 8'h00;
    assign fin       = last_now;
    assign cks_go    = 1'b0;
    // A short body is only known to have ended once i_ts_en drops.
    assign o_eof     = eof_q | last_now;
`endif

    // Header byte selected by the SEND_HDR index.
    always_comb begin
        hdr_byte = head_q[7];
        unique case (hidx_q)
            4'd1:    hdr_byte = seq_q[15:8];
            4'd2:    hdr_byte = seq_q[7:0];
            4'd3:    hdr_byte = HDR_FLAGS;
            4'd4:    hdr_byte = head_q[2];
            4'd5:    hdr_byte = head_q[3];
            4'd6:    hdr_byte = head_q[4];
            4'd7:    hdr_byte = head_q[5];
            4'd8:    hdr_byte = head_q[6];
            default: hdr_byte = head_q[7];
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (i_ready) state_d = ST_REQ_HEAD;
            ST_REQ_HEAD: state_d = ST_GET_HEAD;
            ST_GET_HEAD: begin
                if (hdr_go)   state_d = ST_SEND_HDR;
                else if (tmo) state_d = ST_IDLE;
            end
            ST_SEND_HDR: if (hidx_q == 4'd9) state_d = ST_BODY;
            ST_BODY: begin
                if (fin)      state_d = ST_DONE;
                else if (tmo) state_d = ST_IDLE;
            end
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values per state.
    always_comb begin
        head_d = head_q;
        hcnt_d = hcnt_q;
        hidx_d = hidx_q;
        bcnt_d = bcnt_q;
        full_d = full_q;
        seq_d  = seq_q;
        fcnt_d = fcnt_q;
        idle_d = idle_run ? idle_q + 16'd1 : 16'd0;
        data_d = 8'h00;
        den_d  = 1'b0;
        sof_d  = 1'b0;
        eof_d  = 1'b0;
        ack_d  = 1'b0;
        lerr_d = 1'b0;
        ck_clr = 1'b0;
        ck_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                hcnt_d = 3'd0;
                bcnt_d = 16'd0;
                full_d = 1'b0;
                ack_d  = i_ready;
            end
            ST_REQ_HEAD: begin
            end
            ST_GET_HEAD: begin
                if (i_ts_en) begin
                    head_d[hcnt_q] = iv_ts;
                    hcnt_d = hcnt_q + 3'd1;
                    if (hdr_go) begin
                        data_d = TS_SYNC_BYTE;
                        den_d  = 1'b1;
                        sof_d  = 1'b1;
                        hidx_d = 4'd1;
                        ck_clr = 1'b1;
                    end
                end else if (tmo) begin
                    lerr_d = 1'b1;
                end
            end
            ST_SEND_HDR: begin
                data_d = hdr_byte;
                den_d  = 1'b1;
                ck_en  = (hidx_q >= 4'd4);
                ack_d  = (hidx_q == 4'd7);
                hidx_d = hidx_q + 4'd1;
            end
            ST_BODY: begin
                if (fin) begin
                    lerr_d = frame_len(bcnt_q) != {head_q[0], head_q[1]};
                    seq_d  = seq_q + 16'd1;
                    fcnt_d = fcnt_q + 16'd1;
                end else if (cks_go) begin
                    data_d = ck_acc;
                    den_d  = 1'b1;
                    eof_d  = 1'b1;
                end else if (tmo) begin
                    den_d  = 1'b1;
                    eof_d  = 1'b1;
                    lerr_d = 1'b1;
                end else if (i_ts_en && !full_q) begin
                    data_d = iv_ts;
                    den_d  = 1'b1;
                    ck_en  = 1'b1;
                    bcnt_d = bcnt_q + 16'd1;
                    full_d = (bcnt_q == 16'(BODY_LEN - 1));
                end
            end
            ST_DONE: begin
            end
            default: begin
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            head_q <= '{default: 8'h00};
            hcnt_q <= 3'd0;
            hidx_q <= 4'd0;
            bcnt_q <= 16'd0;
            idle_q <= 16'd0;
            full_q <= 1'b0;
            seq_q  <= 16'd0;
            fcnt_q <= 16'd0;
            data_q <= 8'h00;
            den_q  <= 1'b0;
            sof_q  <= 1'b0;
            eof_q  <= 1'b0;
            ack_q  <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            head_q <= head_d;
            hcnt_q <= hcnt_d;
            hidx_q <= hidx_d;
            bcnt_q <= bcnt_d;
            idle_q <= idle_d;
            full_q <= full_d;
            seq_q  <= seq_d;
            fcnt_q <= fcnt_d;
            data_q <= data_d;
            den_q  <= den_d;
            sof_q  <= sof_d;
            eof_q  <= eof_d;
            ack_q  <= ack_d;
            lerr_q <= lerr_d;
        end
    end

    assign ov_data      = data_q;
    assign o_data_en    = den_q;
    assign o_sof        = sof_q;
    assign o_ack        = ack_q;
    assign o_len_err    = lerr_q;
    assign ov_frame_cnt = fcnt_q;

endmodule

// File: tb/tb_ts_frame_tx.sv
// tb_ts_frame_tx: scoreboard bench for ts_frame_tx with an upstream model.
// Build with TS_FRAME_CHK_EN to exercise the checksum variant.
module tb_ts_frame_tx;
    import ts_frame_pkg::*;

    typedef logic [7:0] head_t [8];
    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eof;
    } obyte_t;
    typedef struct packed {
        logic        lerr;
        logic [15:0] cnt;
    } fend_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b0;
    logic        ts_en = 1'b0;
    logic [7:0]  ts = 8'h00;
    logic        ack, den, sof, eof, lerr;
    logic [7:0]  dout;
    logic [15:0] fcnt;

    int checks = 0;
    int errors = 0;
    int acks = 0;
    int acks_exp = 0;
    bit mon_off = 1'b0;
    bit in_frame = 1'b0;
    bit prev_eof = 1'b0;
    logic [15:0] seq_m = 16'd0;
    logic [15:0] cnt_m = 16'd0;
    obyte_t exp_q[$];
    fend_t  end_q[$];

    always #5 clk = ~clk;

    ts_frame_tx dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_ready      (rdy),
        .o_ack        (ack),
        .iv_ts        (ts),
        .i_ts_en      (ts_en),
        .ov_data      (dout),
        .o_data_en    (den),
        .o_sof        (sof),
        .o_eof        (eof),
        .o_len_err    (lerr),
        .ov_frame_cnt (fcnt)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] body_byte(input int pat, input int k);
        if (pat == 1) return 8'hFF;
        return 8'(k * 3 + pat);
    endfunction

    // Expected output frame and frame-end record.
    task automatic push_frame(input head_t h, input int n, input int pat);
        logic [7:0]  x;
        logic [7:0]  b;
        logic [15:0] len;
        obyte_t      e;
        x = 8'h00;
        exp_q.push_back('{8'h5A, 1'b1, 1'b0});
        exp_q.push_back('{seq_m[15:8], 1'b0, 1'b0});
        exp_q.push_back('{seq_m[7:0], 1'b0, 1'b0});
`ifdef TS_FRAME_CHK_EN
        exp_q.push_back('{8'h01, 1'b0, 1'b0});
`else
        exp_q.push_back('{8'h00, 1'b0, 1'b0});
`endif
        for (int i = 2; i < 8; i++) begin
            exp_q.push_back('{h[i], 1'b0, 1'b0});
            x = x ^ h[i];
        end
        for (int k = 0; k < n; k++) begin
            b = body_byte(pat, k);
            x = x ^ b;
            exp_q.push_back('{b, 1'b0, 1'b0});
        end
`ifdef TS_FRAME_CHK_EN
        exp_q.push_back('{x, 1'b0, 1'b0});
`endif
        e = exp_q.pop_back();
        e.eof = 1'b1;
        exp_q.push_back(e);
        len = 16'(n + 8);
        seq_m = seq_m + 16'd1;
        cnt_m = cnt_m + 16'd1;
        end_q.push_back('{({h[0], h[1]} != len), cnt_m});
    endtask

    task automatic wait_end(input int limit);
        int t;
        t = 0;
        while (end_q.size() != 0 && t < limit) begin
            @(posedge clk); #1;
            t++;
        end
        if (end_q.size() != 0) begin
            chk("frame_end_wait", end_q.size(), 0);
            end_q.delete();
        end
    endtask

    // Upstream mux model; n<0 sends nothing, abort_at>=0 resets mid-body.
    task automatic up_frame(input head_t h, input int n, input int pat,
                            input int abort_at);
        int w;
        rdy = 1'b1;
        @(posedge clk); #1;
        chk("ack1", ack, 1);
        acks_exp++;
        rdy = 1'b0;
        @(posedge clk); #1;
        chk("ack1_width", ack, 0);
        if (n < 0) begin
            wait_end(400);
            return;
        end
        for (int i = 0; i < 8; i++) begin
            ts = h[i];
            ts_en = 1'b1;
            @(posedge clk); #1;
        end
        ts_en = 1'b0;
        ts = 8'h00;
        w = 1;
        while (!ack && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("ack2_delay", w, 8);
        acks_exp++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int k = 0; k < n; k++) begin
            ts = body_byte(pat, k);
            ts_en = 1'b1;
            if (k == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                chk("rst_mid_body",
                    {dout, den, sof, eof, ack, lerr, fcnt}, 0);
                rst = 1'b0;
                ts_en = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        ts_en = 1'b0;
        ts = 8'h00;
        wait_end(20);
    endtask

    // Monitor: pops expected bytes and frame-end records as they appear.
    always @(negedge clk) begin
        obyte_t e;
        fend_t  f;
        if (ack) acks++;
        if (!mon_off && !rst) begin
            if (in_frame) chk("frame_gap", den, 1);
            if (den) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_byte: got %0h want none", dout);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_byte", {dout, sof, eof}, {e.d, e.sof, e.eof});
                end
            end
            if (prev_eof || lerr) begin
                if (end_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL len_err: got %0b want none", lerr);
                end else begin
                    f = end_q.pop_front();
                    chk("len_err", lerr, f.lerr);
                    chk("frame_cnt", fcnt, f.cnt);
                end
            end
            if (den && sof) in_frame = 1'b1;
            if (den && eof) in_frame = 1'b0;
            prev_eof = den && eof;
        end
    end

    initial begin
        head_t hn, hb, hm, hz;
        hn = '{8'h05, 8'h2C, 8'h47, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        hb = '{8'h05, 8'h2C, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
        hm = '{8'h05, 8'h2B, 8'h47, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        hz = '{8'h05, 8'h2C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {dout, den, sof, eof, ack, lerr, fcnt}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        end_q.push_back('{1'b1, 16'd0});
        up_frame(hn, -1, 0, -1);

        push_frame(hn, 1316, 0);
        up_frame(hn, 1316, 0, -1);
        push_frame(hb, 1316, 2);
        up_frame(hb, 1316, 2, -1);
        push_frame(hn, 1316, 5);
        up_frame(hn, 1316, 5, -1);

        push_frame(hm, 1316, 9);
        up_frame(hm, 1316, 9, -1);

        push_frame(hn, 1000, 7);
        up_frame(hn, 1000, 7, -1);

`ifdef TS_FRAME_CHK_EN
        push_frame(hz, 1316, 1);
        up_frame(hz, 1316, 1, -1);
`endif

        mon_off = 1'b1;
        up_frame(hz, 1316, 1, 50);
        repeat (3) @(posedge clk);
        #1;
        chk("ack_count", acks, acks_exp);
        chk("exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
